serial_sub8: RTL and testbench
==============================

// Module: serial_sub8
//
// PURPOSE
// Bit-serial unsigned subtractor: diff = a - b (mod 2**WIDTH) plus borrow-out,
// one bit per clock, LSB first. Inverse arithmetic companion to the parallel
// 8-bit adder. Trades latency for area in datapaths where subtraction is rare.
// Operands enter and the result leaves over independent valid/ready handshakes.
//
// PARAMETERS
// WIDTH  8  operand/result width in bits; legal range 2..32
//
// PORTS
// clk        in   1      single clock; all state updates on rising edge
// rst        in   1      synchronous, active-high reset
// in_valid   in   1      operand pair a/b is valid
// in_ready   out  1      block can accept operands (high only in IDLE, low while rst)
// a          in   WIDTH  minuend, unsigned
// b          in   WIDTH  subtrahend, unsigned
// out_valid  out  1      diff/borrow hold a completed result
// out_ready  in   1      consumer accepts result
// diff       out  WIDTH  (a - b) mod 2**WIDTH
// borrow     out  1      1 iff a < b (unsigned)
//
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, count=0, borrow reg=0, diff=0,
//   out_valid=0; in_ready=0 while rst=1. Reset mid-operation aborts; the result
//   is discarded and never presented.
// - FSM states: IDLE, BUSY, DONE.
//   IDLE: in_ready=1. Edge with in_valid&in_ready: latch a,b into shift regs,
//     borrow reg=0, count=0 -> BUSY.
//   BUSY: in_ready=0, out_valid=0. Each edge processes bit count:
//     d  = a[0] ^ b[0] ^ br;  br' = (~a[0] & b[0]) | (~(a[0]^b[0]) & br);
//     a,b shift right; d shifts into diff MSB; count++.
//     After the edge processing count==WIDTH-1 -> DONE.
//   DONE: out_valid=1; diff/borrow stable while out_valid & ~out_ready.
//     Edge with out_valid&out_ready -> IDLE.
// - Latency: out_valid rises exactly WIDTH cycles after the accept edge.
// - Throughput: one operation per WIDTH+2 cycles minimum; no accept in the
//   cycle of result handshake (in_ready rises the cycle after).
// - in_valid, a, b are ignored outside IDLE; out_ready is ignored outside DONE.
// - borrow output = final br; diff equals a + ~b + 1 truncated to WIDTH.
// - diff holds its last value in IDLE (not cleared) until the next result.
// - count width = $clog2(WIDTH); no wrap occurs since exit at WIDTH-1.
//
// STRUCTURE
// - Package serial_sub_pkg: state_t enum {IDLE, BUSY, DONE}.
// - Sub-module full_subtractor (1-bit: a, b, bin -> d, bout), instantiated
//   once for the serial bit slice.
// - FSM, counter and shift registers live in serial_sub8.
//
// TESTING
// - 5 - 3: out_valid at accept+8 cycles; diff=8'h02, borrow=0.
// - 3 - 5: diff=8'hFE, borrow=1.
// - 8'h00 - 8'h00 and 8'hFF - 8'hFF -> diff=0, borrow=0;
//   8'h00 - 8'hFF -> diff=8'h01, borrow=1.
// - Backpressure: hold out_ready=0 for 10 cycles after out_valid; diff/borrow
//   stable; in_ready=0 throughout; new in_valid with other operands ignored.
// - Assert rst 3 cycles into BUSY: next cycle out_valid=0, in_ready=1 after
//   release; the following op 0x80-0x01 returns diff=8'h7F, borrow=0.
// - Random 1000 back-to-back ops with random ready stalls vs reference model;
//   also WIDTH=16 build: 16'h0000 - 16'h0001 -> 16'hFFFF, borrow=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states. IDLE is encoded as zero so a cleared register is IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; in_valid/a/b are only looked at in IDLE, out_ready only in DONE,
// and diff/borrow stay stable while out_valid is high and out_ready is low.
// fsm_state mirrors the controller state for observation.
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [1:0]       fsm_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    // The minuend register doubles as the result collector: each difference
    // bit enters at the MSB as the consumed operand bit leaves at the LSB.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bit_d;
    logic             bit_bout;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Controller, bit counter, operand shift registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            br       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= 1'b0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh <= {bit_d, a_sh[WIDTH-1:1]};
                    b_sh <= b_sh >> 1;
                    br   <= bit_bout;
                    if (count == LAST) begin
                        // Publish only complete results; diff keeps the old
                        // value during the whole serial pass.
                        diff_q   <= {bit_d, a_sh[WIDTH-1:1]};
                        borrow_q <= bit_bout;
                        state    <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state; in_ready is held low during reset.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        diff      = diff_q;
        borrow    = borrow_q;
        fsm_state = state;
    end

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: directed corners, backpressure,
// mid-operation reset and randomized back-to-back traffic against a model
// that uses plain integer subtraction.
module tb_serial_sub8;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [1:0]       fsm_state;

    int checks;
    int errors;

    // Expected results in issue order: {borrow, diff}.
    logic [WIDTH:0] exp_q[$];

    serial_sub8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned subtraction modulo 2**WIDTH, borrow when a < b.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] d;
        logic             br;
        d  = av - bv;
        br = (av < bv) ? 1'b1 : 1'b0;
        return {br, d};
    endfunction

    // Driver: offer an operand pair until accepted (bounded), log the expectation.
    task automatic send_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, output bit to);
        int n;
        to       = 1'b0;
        n        = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
        end else begin
            tick();
            exp_q.push_back(model(av, bv));
        end
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
    endtask

    // Driver: count cycles from the accept edge until out_valid (bounded).
    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        to = !out_valid;
    endtask

    // Driver: capture the presented result and complete the output handshake.
    task automatic take_result(output logic [WIDTH-1:0] d, output logic br);
        d         = diff;
        br        = borrow;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 8'h12;
        b         = 8'h34;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if (diff !== '0) begin errors++; $display("FAIL reset_diff got %h want 0", diff); end
        checks++;
        if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
        checks++;
        if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[8];
        logic [WIDTH-1:0] tbv[8];
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] d;
        logic             br;
        int               lat;
        bit               to;
        ta  = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h80};
        tbv = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h80};
        for (int i = 0; i < 8; i++) begin
            send_op(ta[i], tbv[i], to);
            checks++;
            if (to) begin errors++; $display("FAIL dir_accept_timeout case %0d", i); continue; end
            wait_valid(lat, to);
            checks++;
            if (to || lat != WIDTH) begin
                errors++;
                $display("FAIL dir_latency case %0d got %0d want %0d", i, lat, WIDTH);
            end
            if (to) begin void'(exp_q.pop_front()); continue; end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL dir_in_ready_done case %0d got %b want 0", i, in_ready); end
            e = exp_q.pop_front();
            take_result(d, br);
            checks++;
            if (d !== e[WIDTH-1:0]) begin errors++; $display("FAIL dir_diff case %0d got %h want %h", i, d, e[WIDTH-1:0]); end
            checks++;
            if (br !== e[WIDTH]) begin errors++; $display("FAIL dir_borrow case %0d got %b want %b", i, br, e[WIDTH]); end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir_after_handshake case %0d in_ready %b out_valid %b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] d;
        logic             br;
        int               lat;
        bit               to;
        send_op(8'hA5, 8'hC3, to);
        if (!to) wait_valid(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout no result presented"); exp_q.delete(); return; end
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            checks++;
            if (out_valid !== 1'b1 || diff !== e[WIDTH-1:0] || borrow !== e[WIDTH]) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b d=%h br=%b want v=1 d=%h br=%b",
                         i, out_valid, diff, borrow, e[WIDTH-1:0], e[WIDTH]);
            end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        take_result(d, br);
        checks++;
        if (d !== e[WIDTH-1:0] || br !== e[WIDTH]) begin
            errors++;
            $display("FAIL bp_result got %h/%b want %h/%b", d, br, e[WIDTH-1:0], e[WIDTH]);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_ghost_result cycle %0d got out_valid %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] msb_only;
        logic             br;
        int               lat;
        bit               to;
        send_op(8'h3C, 8'h11, to);
        exp_q.delete();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got out_valid %b in_ready %b want 0 0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_aborted_result cycle %0d got %b want 0", i, out_valid); end
        end
        msb_only = '0;
        msb_only[WIDTH-1] = 1'b1;
        send_op(msb_only, 8'h01, to);
        if (!to) wait_valid(lat, to);
        checks++;
        if (to || lat != WIDTH) begin errors++; $display("FAIL mid_next_latency got %0d want %0d", lat, WIDTH); end
        if (to) begin exp_q.delete(); return; end
        e = exp_q.pop_front();
        take_result(d, br);
        checks++;
        if (d !== e[WIDTH-1:0] || br !== e[WIDTH]) begin
            errors++;
            $display("FAIL mid_next_result got %h/%b want %h/%b", d, br, e[WIDTH-1:0], e[WIDTH]);
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             br;
        int               lat;
        int               stall;
        bit               to;
        for (int n = 0; n < 1000; n++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            case ($urandom_range(0, 7))
                0: av = '0;
                1: bv = '1;
                2: bv = av;
                default: ;
            endcase
            repeat ($urandom_range(0, 1)) tick();
            send_op(av, bv, to);
            if (!to) wait_valid(lat, to);
            checks++;
            if (to || lat != WIDTH) begin
                errors++;
                $display("FAIL rnd_latency op %0d got %0d want %0d", n, lat, WIDTH);
            end
            if (to) begin exp_q.delete(); return; end
            stall = $urandom_range(0, 3);
            repeat (stall) tick();
            e = exp_q.pop_front();
            take_result(d, br);
            checks++;
            if (d !== e[WIDTH-1:0] || br !== e[WIDTH]) begin
                errors++;
                $display("FAIL rnd_result op %0d a=%h b=%h got %h/%b want %h/%b",
                         n, av, bv, d, br, e[WIDTH-1:0], e[WIDTH]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
